au_result_fifo: RTL and testbench
=================================

Name: au_result_fifo

Overview:
- Result buffer that sits directly downstream of the arithmetic unit's 32-bit 4:1 result mux.
- Each cycle the mux output is valid, the block captures the 32-bit value and the 2-bit select code that produced it as a tag.
- It holds up to DEPTH entries and presents them first-word-fall-through to the consumer (register file write-back / display stage) with a valid/ready handshake.
- Decouples consumer stalls from the arithmetic unit and flags results dropped while full.

Parameters:
- WIDTH, 32, data width; equals the mux output width.
- DEPTH, 4, number of entries; power of 2, at least 2.
- AW, 2, pointer width; log2(DEPTH).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_data  input  WIDTH  result from the 4:1 mux output.
- in_sel  input  2  {s1,S0} select that produced in_data; stored as tag.
- in_valid  input  1  producer has a result this cycle.
- in_ready  output  1  buffer can accept; equals !full, forced 0 while rst_n=0.
- out_data  output  WIDTH  oldest stored result.
- out_sel  output  2  tag of oldest result.
- out_valid  output  1  out_data/out_sel hold a valid entry.
- out_ready  input  1  consumer accepts this cycle.
- count  output  AW+1  entries stored, 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- overflow  output  1  sticky: a result was dropped.
- clr_ovf  input  1  one-cycle pulse that clears overflow.

Behaviour:
- Reset (rst_n=0 at a rising edge): wr_ptr=rd_ptr=0, count=0, overflow=0.
  - Outputs after that edge: empty=1, full=0, out_valid=0, out_data=0, out_sel=0.
  - in_ready=0 combinationally while rst_n=0, and 1 on the first cycle after reset is released.
  - Storage array contents are not reset.
  - Reset mid-operation discards all entries; no partial pop or push completes on that edge.
- Push: when in_valid && in_ready at an edge, write {in_sel,in_data} at wr_ptr, then wr_ptr+1 mod DEPTH.
- Pop: when out_valid && out_ready at an edge, rd_ptr+1 mod DEPTH.
- count update: push-only +1, pop-only -1, both or neither unchanged.
- Latency: a push into an empty buffer is visible on out_data/out_valid one cycle later. There is no same-cycle bypass.
- FWFT: out_valid = !empty; out_data/out_sel = entry at rd_ptr when non-empty, otherwise driven to 0.
- out_data and out_sel stay stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop:
  - Non-empty, non-full: both occur, count unchanged, no data corruption.
  - Empty: only the push occurs, since out_valid=0.
  - Full: only the pop occurs, since in_ready=0. The producer must hold or the result is dropped.
- Drop: if in_valid=1 and full=1 at an edge (ignoring reset), the data is discarded and overflow is set to 1.
- overflow stays set until clr_ovf=1 or reset.
- If clr_ovf=1 and a drop occur on the same edge, set wins and overflow=1.
- Pointer wrap: pointers are AW bits and wrap from DEPTH-1 to 0. full/empty come from count, not from pointer comparison.
- No combinational path from in_valid/in_data to any output. in_ready depends only on registered count and rst_n.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release -> count=0, empty=1, full=0, out_valid=0, out_data=0, overflow=0, in_ready=1.
- Single pass: push in_data=32'hDEADBEEF, in_sel=2'b10 with out_ready=0 -> next cycle out_valid=1, out_data=DEADBEEF, out_sel=10, count=1; then out_ready=1 for one cycle -> empty=1.
- Fill and order: push 1,2,3,4 (sel 00,01,10,11) with out_ready=0 -> full=1, in_ready=0, count=4. Drain -> outputs 1,2,3,4 in order with matching tags.
- Overflow: while full, drive in_valid=1, in_data=5 -> count stays 4, overflow=1, value 5 never appears. Pulse clr_ovf -> overflow=0.
- Wrap with concurrent traffic: hold in_valid=out_ready=1 for 10 cycles pushing 10..19 starting from count=2 -> count stays 2 throughout, all values emerge in order across two pointer wraps.
- Reset mid-operation: with count=3, assert rst_n=0 for one cycle -> count=0, out_valid=0. Next push of 32'hA5A5A5A5 is the first output.

Source files
------------

// File: rtl/au_result_fifo_if.sv
// Handshake bundle between the arithmetic unit result mux, the result FIFO and its consumer.
interface au_result_fifo_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
);
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;
    logic             out_valid;
    logic             out_ready;
    logic [AW:0]      count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             clr_ovf;

    // Producer/consumer side: drives the inputs, observes the status.
    modport master (
        output in_data, in_sel, in_valid, out_ready, clr_ovf,
        input  in_ready, out_data, out_sel, out_valid, count, full, empty, overflow
    );

    // FIFO side.
    modport slave (
        input  in_data, in_sel, in_valid, out_ready, clr_ovf,
        output in_ready, out_data, out_sel, out_valid, count, full, empty, overflow
    );
endinterface

// File: rtl/au_result_fifo.sv
// First-word-fall-through result buffer behind the arithmetic unit's 4:1 result mux.
// Stores {select tag, data} per entry; flags results dropped while full.
module au_result_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input logic              clk,
    input logic              rst_n,
    au_result_fifo_if.slave  bus
);
    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    logic [WIDTH+1:0] mem_q [DEPTH];
    logic [WIDTH+1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;

    logic full, empty, push, pop, drop;

    assign full  = (count_q == FullCount);
    assign empty = (count_q == '0);
    assign push  = bus.in_valid && !full;
    assign pop   = !empty && bus.out_ready;
    assign drop  = bus.in_valid && full;

    // Next-state: pointers, occupancy, sticky overflow and the written entry.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            mem_d[wr_ptr_q] = {bus.in_sel, bus.in_data};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        // A drop on the same edge as a clear leaves the flag set.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (bus.clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; a write only lands outside reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            mem_q <= mem_d;
        end
    end

    // Outputs come only from registered state (plus rst_n gating in_ready).
    always_comb begin
        bus.in_ready  = rst_n && !full;
        bus.out_valid = !empty;
        bus.out_data  = '0;
        bus.out_sel   = '0;
        if (!empty) begin
            bus.out_data = mem_q[rd_ptr_q][WIDTH-1:0];
            bus.out_sel  = mem_q[rd_ptr_q][WIDTH+1:WIDTH];
        end
        bus.count    = count_q;
        bus.full     = full;
        bus.empty    = empty;
        bus.overflow = overflow_q;
    end
endmodule

// File: tb/tb_au_result_fifo.sv
// Self-checking bench for au_result_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_au_result_fifo;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    au_result_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) bus ();

    au_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: entries as {sel, data}, oldest at index 0.
    logic [WIDTH+1:0] mq[$];
    logic             m_ovf = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, check outputs, advance model on the edge.
    task automatic step(input logic rst, input logic vld, input logic [WIDTH-1:0] d,
                        input logic [1:0] s, input logic ordy, input logic clr);
        int  sz;
        logic do_push, do_pop, do_drop;
        rst_n         = rst;
        bus.in_valid  = vld;
        bus.in_data   = d;
        bus.in_sel    = s;
        bus.out_ready = ordy;
        bus.clr_ovf   = clr;
        #1;
        sz = mq.size();
        check_eq("count", 64'(bus.count), 64'(sz));
        check_eq("empty", 64'(bus.empty), 64'(sz == 0));
        check_eq("full", 64'(bus.full), 64'(sz == DEPTH));
        check_eq("out_valid", 64'(bus.out_valid), 64'(sz != 0));
        check_eq("out_data", 64'(bus.out_data), (sz != 0) ? 64'(mq[0][WIDTH-1:0]) : 64'd0);
        check_eq("out_sel", 64'(bus.out_sel), (sz != 0) ? 64'(mq[0][WIDTH+1:WIDTH]) : 64'd0);
        check_eq("overflow", 64'(bus.overflow), 64'(m_ovf));
        check_eq("in_ready", 64'(bus.in_ready), 64'(rst && (sz < DEPTH)));
        @(posedge clk);
        do_push = vld && (sz < DEPTH);
        do_pop  = ordy && (sz > 0);
        do_drop = vld && (sz == DEPTH);
        if (!rst) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back({s, d});
            if (do_drop) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b1, 1'b0, '0, 2'b00, ordy, 1'b0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sel    = '0;
        bus.out_ready = 1'b0;
        bus.clr_ovf   = 1'b0;
        @(negedge clk);

        // Reset held for two cycles, then idle.
        step(1'b0, 1'b0, '0, 2'b00, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 2'b00, 1'b0, 1'b0);
        idle(1'b0);

        // Single pass.
        step(1'b1, 1'b1, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // Fill, overflow, clear, drain.
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 32'(i), 2'(i - 1), 1'b0, 1'b0);
        idle(1'b0);
        step(1'b1, 1'b1, 32'd5, 2'b00, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'd5, 2'b01, 1'b0, 1'b1);
        step(1'b1, 1'b0, '0, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Concurrent push/pop at count=2 across pointer wraps.
        step(1'b1, 1'b1, 32'd8, 2'b00, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'd9, 2'b01, 1'b0, 1'b0);
        for (int i = 10; i < 20; i++) step(1'b1, 1'b1, 32'(i), 2'(i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Reset mid-operation with a push and pop requested on the reset edge.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'(100 + i), 2'(i), 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h12345678, 2'b11, 1'b1, 1'b0);
        step(1'b1, 1'b1, 32'hA5A5A5A5, 2'b01, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Random traffic, biased toward full/empty edges and occasional reset.
        for (int i = 0; i < 400; i++) begin
            logic r;
            r = ($urandom_range(0, 49) != 0);
            step(r, 1'($urandom_range(0, 2) != 0), $urandom, 2'($urandom),
                 1'($urandom_range(0, 2) == 0 || i > 200), 1'($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
